// File: rtl/dm_sched.sv
// ---------------------------------------------------------------------------
// dm_sched -- data-memory scheduler
//
// Shares one data memory between three users:
// a byte loader, the processor and the output transmitter.
//   1. LOAD: streams IMG_BYTES loader bytes into the memory from address 0.
//   2. PROC: hands the memory port to the processor until end_process.
//   3. TX_*: reads OUT_BYTES bytes starting at OUT_BASE.
//      Each byte goes to the transmitter through a valid/ready handshake.
//
// Ports
//   clock, rst_n                    : clock, asynchronous active-low reset
//   start                           : host pulse, accepted in IDLE and DONE
//   ld_valid, ld_data, ld_ready     : loader byte stream
//   p_dm_r, p_dm_wr, p_addr, p_din  : processor memory requests
//   end_process                     : processor finished
//   tx_valid, tx_data, tx_ready     : output byte stream
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            : data-memory port (read latency 1)
//   status, done                    : phase indication
// ---------------------------------------------------------------------------
module dm_sched #(
    parameter int unsigned IMG_BYTES = 65536,
    parameter logic [19:0] OUT_BASE  = 20'h10000,
    parameter int unsigned OUT_BYTES = 16384
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        p_dm_r,
    input  logic        p_dm_wr,
    input  logic [19:0] p_addr,
    input  logic [7:0]  p_din,
    input  logic        end_process,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [1:0]  status,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PROC,
        TX_RD,
        TX_WAIT,
        TX_SEND,
        DONE
    } state_t;

    // Last counter values of each transfer, truncated to the 20-bit counters.
    localparam logic [19:0] LD_LAST = 20'(IMG_BYTES - 1);
    localparam logic [19:0] TX_LAST = 20'(OUT_BYTES - 1);

    state_t      state_q, state_d;
    logic [19:0] ld_addr_q, ld_addr_d;
    logic [19:0] tx_addr_q, tx_addr_d;
    logic [7:0]  tx_data_q, tx_data_d;

    // State and datapath registers.
    // Reset is asynchronous, so the phase outputs decoded from state_q
    // drop to their idle values immediately, even in the middle of a transfer.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ld_addr_q <= '0;
            tx_addr_q <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            tx_addr_q <= tx_addr_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state and output decode.
    // Every output first takes its idle value. Each state then drives only
    // what it owns, so processor requests outside PROC cannot reach memory.
    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        tx_addr_d = tx_addr_q;
        tx_data_d = tx_data_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_ready  = 1'b0;
        tx_valid  = 1'b0;
        status    = 2'b00;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    ld_addr_d = '0;
                    tx_addr_d = '0;
                end
            end

            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_addr_q;
                    mem_wdata = ld_data;
                    ld_addr_d = ld_addr_q + 20'd1;
                    if (ld_addr_q == LD_LAST) begin
                        state_d = PROC;
                    end
                end
            end

            PROC: begin
                status    = 2'b01;
                mem_en    = p_dm_r | p_dm_wr;
                mem_we    = p_dm_wr;
                mem_addr  = p_addr;
                mem_wdata = p_din;
                if (end_process) begin
                    state_d = TX_RD;
                end
            end

            TX_RD: begin
                status   = 2'b10;
                mem_en   = 1'b1;
                mem_addr = OUT_BASE + tx_addr_q;
                state_d  = TX_WAIT;
            end

            // Read data from the TX_RD access is on mem_rdata in this cycle.
            TX_WAIT: begin
                status    = 2'b10;
                tx_data_d = mem_rdata;
                state_d   = TX_SEND;
            end

            TX_SEND: begin
                status   = 2'b10;
                tx_valid = 1'b1;
                if (tx_ready) begin
                    if (tx_addr_q == TX_LAST) begin
                        state_d = DONE;
                    end else begin
                        tx_addr_d = tx_addr_q + 20'd1;
                        state_d   = TX_RD;
                    end
                end
            end

            DONE: begin
                status = 2'b11;
                done   = 1'b1;
                if (start) begin
                    state_d   = LOAD;
                    ld_addr_d = '0;
                    tx_addr_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_data = tx_data_q;

endmodule

// File: tb/tb_dm_sched.sv
// ---------------------------------------------------------------------------
// tb_dm_sched -- self-checking bench for dm_sched
//
// Sets IMG_BYTES=4, OUT_BASE=8, OUT_BYTES=2.
// A small behavioural memory stands in for the data memory.
// A cycle table drives one full pass through load, process and readback.
// Hand sequences then cover restart from DONE, reset during TX_SEND,
// and start after reset.
// ---------------------------------------------------------------------------
module tb_dm_sched;

    typedef struct packed {
        logic        start;
        logic        ld_valid;
        logic [7:0]  ld_data;
        logic        p_dm_r;
        logic        p_dm_wr;
        logic [19:0] p_addr;
        logic [7:0]  p_din;
        logic        end_process;
        logic        tx_ready;
    } ins_t;

    typedef struct packed {
        logic        mem_en;
        logic        mem_we;
        logic [19:0] mem_addr;
        logic [7:0]  mem_wdata;
        logic [1:0]  status;
        logic        ld_ready;
        logic        tx_valid;
        logic [7:0]  tx_data;
        logic        done;
    } outs_t;

    typedef struct {
        ins_t  ins;
        outs_t exp;
    } vec_t;

    logic        clock;
    logic        rst_n;
    logic        start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        p_dm_r;
    logic        p_dm_wr;
    logic [19:0] p_addr;
    logic [7:0]  p_din;
    logic        end_process;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_en;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  status;
    logic        done;

    int checks;
    int failures;

    logic [7:0] mem_model [16];

    vec_t tbl[$];

    dm_sched #(
        .IMG_BYTES (4),
        .OUT_BASE  (20'h8),
        .OUT_BYTES (2)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .p_dm_r      (p_dm_r),
        .p_dm_wr     (p_dm_wr),
        .p_addr      (p_addr),
        .p_din       (p_din),
        .end_process (end_process),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .status      (status),
        .done        (done)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural data memory with 16 bytes and a one-cycle read latency.
    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            mem_model[mem_addr[3:0]] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= mem_model[mem_addr[3:0]];
        end
    end

    // Stops the run if the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic ins_t mkIn(input logic st, input logic lv, input logic [7:0] ld,
                                  input logic pr, input logic pw, input logic [19:0] pa,
                                  input logic [7:0] pd, input logic ep, input logic tr);
        ins_t i;
        i.start       = st;
        i.ld_valid    = lv;
        i.ld_data     = ld;
        i.p_dm_r      = pr;
        i.p_dm_wr     = pw;
        i.p_addr      = pa;
        i.p_din       = pd;
        i.end_process = ep;
        i.tx_ready    = tr;
        return i;
    endfunction

    function automatic outs_t mkOut(input logic en, input logic we, input logic [19:0] addr,
                                    input logic [7:0] wd, input logic [1:0] st,
                                    input logic ldr, input logic txv, input logic [7:0] txd,
                                    input logic dn);
        outs_t o;
        o.mem_en    = en;
        o.mem_we    = we;
        o.mem_addr  = addr;
        o.mem_wdata = wd;
        o.status    = st;
        o.ld_ready  = ldr;
        o.tx_valid  = txv;
        o.tx_data   = txd;
        o.done      = dn;
        return o;
    endfunction

    // Waits for the falling edge, drives one cycle of inputs,
    // then lets the combinational outputs settle.
    task automatic applyStimulus(input ins_t i);
        @(negedge clock);
        start       = i.start;
        ld_valid    = i.ld_valid;
        ld_data     = i.ld_data;
        p_dm_r      = i.p_dm_r;
        p_dm_wr     = i.p_dm_wr;
        p_addr      = i.p_addr;
        p_din       = i.p_din;
        end_process = i.end_process;
        tx_ready    = i.tx_ready;
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act.mem_en    = mem_en;
        act.mem_we    = mem_we;
        act.mem_addr  = mem_addr;
        act.mem_wdata = mem_wdata;
        act.status    = status;
        act.ld_ready  = ld_ready;
        act.tx_valid  = tx_valid;
        act.tx_data   = tx_data;
        act.done      = done;
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (en,we,addr,wd,st,ldr,txv,txd,dn)",
                     name, act, exp);
        end
    endtask

    task automatic checkByte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        ins_t  idle_in;
        outs_t zero_out;
        logic [7:0] load2 [4];

        checks   = 0;
        failures = 0;
        for (int k = 0; k < 16; k++) mem_model[k] = 8'h00;
        mem_rdata = 8'h00;

        idle_in  = mkIn(0, 0, 8'h00, 0, 0, 20'h0, 8'h00, 0, 0);
        zero_out = mkOut(0, 0, 20'h0, 8'h00, 2'b00, 0, 0, 8'h00, 0);

        // Cycle table: inputs for the cycle and the outputs seen in it.
        // IDLE: processor read ignored; start; gapped load; start ignored.
        tbl.push_back('{mkIn(0,0,8'h00,1,0,20'h5,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b00,0,0,8'h00,0)});
        tbl.push_back('{mkIn(1,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b00,0,0,8'h00,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b00,1,0,8'h00,0)});
        tbl.push_back('{mkIn(0,1,8'h11,0,0,20'h0,8'h00,0,0), mkOut(1,1,20'h0,8'h11,2'b00,1,0,8'h00,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b00,1,0,8'h00,0)});
        tbl.push_back('{mkIn(0,1,8'h22,0,0,20'h0,8'h00,0,0), mkOut(1,1,20'h1,8'h22,2'b00,1,0,8'h00,0)});
        tbl.push_back('{mkIn(1,1,8'h33,0,0,20'h0,8'h00,0,0), mkOut(1,1,20'h2,8'h33,2'b00,1,0,8'h00,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,1,20'h3,8'h77,0,0), mkOut(0,0,20'h0,8'h00,2'b00,1,0,8'h00,0)});
        tbl.push_back('{mkIn(0,1,8'h44,0,0,20'h0,8'h00,0,0), mkOut(1,1,20'h3,8'h44,2'b00,1,0,8'h00,0)});
        // PROC: write, read+write treated as write, start ignored, read, idle, end.
        tbl.push_back('{mkIn(0,0,8'h00,0,1,20'h8,8'hAA,0,0), mkOut(1,1,20'h8,8'hAA,2'b01,0,0,8'h00,0)});
        tbl.push_back('{mkIn(1,0,8'h00,1,1,20'h9,8'hBB,0,0), mkOut(1,1,20'h9,8'hBB,2'b01,0,0,8'h00,0)});
        tbl.push_back('{mkIn(0,0,8'h00,1,0,20'h2,8'h00,0,0), mkOut(1,0,20'h2,8'h00,2'b01,0,0,8'h00,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b01,0,0,8'h00,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,1,0), mkOut(0,0,20'h0,8'h00,2'b01,0,0,8'h00,0)});
        // TX: read 8, wait, 5 stalled cycles, handshake, read 9, wait, handshake.
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(1,0,20'h8,8'h00,2'b10,0,0,8'h00,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b10,0,0,8'h00,0)});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b10,0,1,8'hAA,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,1), mkOut(0,0,20'h0,8'h00,2'b10,0,1,8'hAA,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(1,0,20'h9,8'h00,2'b10,0,0,8'hAA,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b10,0,0,8'hAA,0)});
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,1), mkOut(0,0,20'h0,8'h00,2'b10,0,1,8'hBB,0)});
        // DONE: processor write ignored.
        tbl.push_back('{mkIn(0,0,8'h00,0,0,20'h0,8'h00,0,0), mkOut(0,0,20'h0,8'h00,2'b11,0,0,8'hBB,1)});
        tbl.push_back('{mkIn(0,0,8'h00,0,1,20'h1,8'h5A,0,0), mkOut(0,0,20'h0,8'h00,2'b11,0,0,8'hBB,1)});

        // Reset values while rst_n is held low.
        rst_n = 1'b0;
        start = 0; ld_valid = 0; ld_data = 0; p_dm_r = 0; p_dm_wr = 0;
        p_addr = 0; p_din = 0; end_process = 0; tx_ready = 0;
        #3;
        checkOutput("reset_state", zero_out);
        @(negedge clock);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            applyStimulus(tbl[k].ins);
            checkOutput($sformatf("row%0d", k), tbl[k].exp);
        end

        checkByte("mem0", mem_model[0], 8'h11);
        checkByte("mem1", mem_model[1], 8'h22);
        checkByte("mem2", mem_model[2], 8'h33);
        checkByte("mem3", mem_model[3], 8'h44);
        checkByte("mem7_untouched", mem_model[7], 8'h00);
        checkByte("mem9", mem_model[9], 8'hBB);

        // Restart from DONE: both counters must be back at 0.
        applyStimulus(mkIn(1,0,8'h00,0,0,20'h0,8'h00,0,0));
        checkOutput("restart_done", mkOut(0,0,20'h0,8'h00,2'b11,0,0,8'hBB,1));
        load2[0] = 8'h55; load2[1] = 8'h66; load2[2] = 8'h77; load2[3] = 8'h88;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mkIn(0,1,load2[k],0,0,20'h0,8'h00,0,0));
            checkOutput($sformatf("reload%0d", k),
                        mkOut(1,1,20'(k),load2[k],2'b00,1,0,8'hBB,0));
        end
        applyStimulus(mkIn(0,0,8'h00,0,0,20'h0,8'h00,1,0));
        checkOutput("proc2_end", mkOut(0,0,20'h0,8'h00,2'b01,0,0,8'hBB,0));
        applyStimulus(idle_in);
        checkOutput("tx2_rd_base", mkOut(1,0,20'h8,8'h00,2'b10,0,0,8'hBB,0));
        applyStimulus(idle_in);
        checkOutput("tx2_wait", mkOut(0,0,20'h0,8'h00,2'b10,0,0,8'hBB,0));
        applyStimulus(idle_in);
        checkOutput("tx2_send", mkOut(0,0,20'h0,8'h00,2'b10,0,1,8'hAA,0));

        // Asynchronous reset during TX_SEND, checked before the next rising edge.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tx", zero_out);
        @(negedge clock);
        rst_n = 1'b1;

        // After reset the block stays idle whatever the other inputs do.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(mkIn(0,1,8'h12,1,1,20'h3,8'h34,1,1));
            checkOutput($sformatf("post_reset_idle%0d", k), zero_out);
        end
        applyStimulus(mkIn(1,0,8'h00,0,0,20'h0,8'h00,0,0));
        checkOutput("post_reset_start", zero_out);
        applyStimulus(mkIn(0,1,8'h99,0,0,20'h0,8'h00,0,0));
        checkOutput("post_reset_load0", mkOut(1,1,20'h0,8'h99,2'b00,1,0,8'h00,0));

        // A start pulse during PROC must have no effect.
        for (int k = 1; k < 4; k++) begin
            applyStimulus(mkIn(0,1,8'h99,0,0,20'h0,8'h00,0,0));
        end
        applyStimulus(mkIn(1,0,8'h00,0,0,20'h0,8'h00,0,0));
        checkOutput("proc3_start", mkOut(0,0,20'h0,8'h00,2'b01,0,0,8'h00,0));
        applyStimulus(idle_in);
        checkOutput("proc3_stays", mkOut(0,0,20'h0,8'h00,2'b01,0,0,8'h00,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_sched.md
DM_SCHED -- requirements
Module: dm_sched

Interface
REQ-001 SHALL have parameter IMG_BYTES, default 65536: number of input image bytes loaded into data memory.
REQ-002 SHALL have parameter OUT_BASE, default 20'h10000: data-memory address of the first output byte.
REQ-003 SHALL have parameter OUT_BYTES, default 16384: number of output bytes read back.
REQ-004 SHALL have the following ports:
  clock  in  1  single clock; all state updates on its rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  start  in  1  one-cycle host pulse that begins a load.
  ld_valid  in  1  loader byte valid.
  ld_data  in  8  loader byte.
  ld_ready  out  1  scheduler can accept a loader byte.
  p_dm_r  in  1  processor read request.
  p_dm_wr  in  1  processor write request.
  p_addr  in  20  processor address.
  p_din  in  8  processor write data.
  end_process  in  1  processor finished.
  tx_valid  out  1  output byte valid.
  tx_data  out  8  output byte.
  tx_ready  in  1  transmitter accepts the byte.
  mem_en  out  1  data-memory access enable.
  mem_we  out  1  data-memory write enable.
  mem_addr  out  20  data-memory address.
  mem_wdata  out  8  data-memory write data.
  mem_rdata  in  8  memory read data, valid one cycle after mem_en with mem_we=0.
  status  out  2  phase: 00 idle/load, 01 process, 10 transmit, 11 done.
  done  out  1  high in DONE.

Function
REQ-005 SHALL implement the FSM IDLE, LOAD, PROC, TX_RD, TX_WAIT, TX_SEND, DONE; status SHALL be 00 in IDLE/LOAD, 01 in PROC, 10 in TX_*, and 11 in DONE.
REQ-006 IDLE: on start=1, SHALL go to LOAD and clear ld_addr and tx_addr to 0; all other inputs are ignored.
REQ-007 LOAD: ld_ready SHALL be 1 (registered state decode); a handshake (ld_valid & ld_ready) SHALL drive mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle and then increment ld_addr.
REQ-008 LOAD: the handshake at ld_addr==IMG_BYTES-1 SHALL move the FSM to PROC on the next edge; ld_valid=0 SHALL stall with no memory access.
REQ-009 PROC: mem_en SHALL equal p_dm_r|p_dm_wr, mem_we=p_dm_wr, mem_addr=p_addr, mem_wdata=p_din, all combinational pass-through; p_dm_r & p_dm_wr together SHALL be treated as a write.
REQ-010 Outside PROC: p_dm_r, p_dm_wr, p_addr and p_din SHALL have no effect on the memory outputs.
REQ-011 PROC: end_process=1 SHALL move the FSM to TX_RD; if an access is requested in the same cycle, it SHALL still be passed through.
REQ-012 TX_RD: SHALL drive mem_en=1, mem_we=0, mem_addr=OUT_BASE+tx_addr (20-bit wrap), then go to TX_WAIT.
REQ-013 TX_WAIT: SHALL capture mem_rdata into the tx_data register and go to TX_SEND.
REQ-014 TX_SEND: tx_valid SHALL be 1 and tx_data SHALL be stable until tx_ready=1; on the handshake the FSM SHALL go to DONE if tx_addr==OUT_BYTES-1, otherwise increment tx_addr and go to TX_RD.
REQ-015 The minimum readback period SHALL be 3 cycles per byte; first tx_valid SHALL be 2 cycles after entering TX_RD.
REQ-016 DONE: done SHALL be 1; start=1 SHALL restart exactly as in IDLE (go to LOAD, clear both counters).
REQ-017 start SHALL be ignored in LOAD, PROC and TX_*.
REQ-018 Defaults when not otherwise driven: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_ready=0, tx_valid=0.
REQ-019 ld_addr and tx_addr SHALL be 20 bits; parameters SHALL satisfy 1<=IMG_BYTES<=2^20 and 1<=OUT_BYTES<=2^20.

Reset
REQ-020 rst_n=0 SHALL, asynchronously and in any state including mid-transfer, force state IDLE, ld_addr=0, tx_addr=0, tx_data=0, status=00, done=0, ld_ready=0, tx_valid=0, mem_en=0, mem_we=0.
REQ-021 After rst_n is released, the block SHALL take no action until start.

Verification (IMG_BYTES=4, OUT_BASE=8, OUT_BYTES=2)
REQ-022 Load: start, then bytes 11,22,33,44 with ld_valid gapped -> writes to addr 0..3 only on handshake cycles; status goes 00->01 one edge after byte 44.
REQ-023 Process: in PROC, p_dm_wr=1, p_addr=8, p_din=AA, then p_dm_r=1 and p_dm_wr=1 at addr 9 with p_din=BB -> mem_we=1 both cycles; p_dm_r in IDLE -> mem_en=0.
REQ-024 Readback backpressure: mem[8]=AA, mem[9]=BB, end_process, tx_ready low for 5 cycles -> tx_valid=1 with tx_data=AA held stable; then BB; then done=1, status=11.
REQ-025 Reset mid-TX: assert rst_n=0 during TX_SEND -> tx_valid=0 and status=00 immediately, without waiting for a clock edge; a later start reloads from address 0.
REQ-026 Restart: start in DONE -> LOAD with counters 0; start during PROC -> no effect.
